// File: rtl/seg_msg_scanner_if.sv
// rtl/seg_msg_scanner_if.sv - message write, control and display bus of the segment scanner
interface seg_msg_scanner_if #(
  parameter int N_DIG     = 4,
  parameter int MSG_DEPTH = 16
);
  localparam int AW = $clog2(MSG_DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [4:0]       wr_data;
  logic [AW:0]      len_i;
  logic             start;
  logic             stop;
  logic             hold;
  logic [4:0]       code_o;
  logic [N_DIG-1:0] dig_an_o;
  logic             blank_o;
  logic             busy;
  logic             wrap_o;

  modport master (
    output wr_en, wr_addr, wr_data, len_i, start, stop, hold,
    input  code_o, dig_an_o, blank_o, busy, wrap_o
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_i, start, stop, hold,
    output code_o, dig_an_o, blank_o, busy, wrap_o
  );
endinterface

// File: rtl/seg_msg_scanner.sv
// rtl/seg_msg_scanner.sv - 7-segment digit multiplexer with scrolling message buffer
// Optional blink gating enabled by defining SEG_SCANNER_BLINK_EN (adds blink_i).
module seg_msg_scanner #(
  parameter int N_DIG         = 4,
  parameter int MSG_DEPTH     = 16,
  parameter int REFRESH_DIV   = 50000,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef SEG_SCANNER_BLINK_EN
  input  logic blink_i,
`endif
  seg_msg_scanner_if.slave bus
);
  localparam int AW  = $clog2(MSG_DEPTH);
  localparam int LW  = AW + 1;
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam int DIW = $clog2(N_DIG);
  localparam int FW  = $clog2(SCROLL_FRAMES);
  localparam logic [31:0] NDIG_U = N_DIG;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic [RCW-1:0]   r_rc;
  logic [DIW-1:0]   r_di;
  logic [FW-1:0]    r_fc;
  logic [LW-1:0]    r_off;
  logic [LW-1:0]    r_len;
  logic [4:0]       r_msg [MSG_DEPTH];
  logic [4:0]       r_code;
  logic [N_DIG-1:0] r_an;
  logic             r_blank;
  logic             r_busy;
  logic             r_wrap;

  logic [LW-1:0]    w_len_clamp;
  logic             w_accept;
  logic             w_active;
  logic             w_tick;
  logic             w_frame_end;
  logic             w_fc_last;
  logic             w_long;
  logic [LW-1:0]    w_off_inc;
  logic [LW-1:0]    w_off_nxt;
  logic [LW-1:0]    w_sum;
  logic [LW-1:0]    w_idx;
  logic [AW-1:0]    w_rd_addr;
  logic             w_blank_dig;
  logic             w_dark;
  logic [N_DIG-1:0] w_an;

  assign w_len_clamp = (bus.len_i > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : bus.len_i;
  assign w_accept    = bus.start && !bus.stop && (w_len_clamp != '0);
  assign w_active    = (r_state != S_IDLE);
  assign w_tick      = (r_rc == RCW'(REFRESH_DIV - 1));
  assign w_frame_end = w_tick && (r_di == DIW'(N_DIG - 1));
  assign w_fc_last   = (r_fc == FW'(SCROLL_FRAMES - 1));
  assign w_long      = (32'(r_len) > NDIG_U);

  // Offset and digit index stay below len, so one conditional subtract is a full modulo.
  assign w_off_inc   = r_off + LW'(1);
  assign w_off_nxt   = (w_off_inc >= r_len) ? '0 : w_off_inc;
  assign w_sum       = r_off + LW'(r_di);
  assign w_idx       = (w_sum >= r_len) ? (w_sum - r_len) : w_sum;
  assign w_rd_addr   = AW'(w_idx);
  assign w_blank_dig = !w_long && (32'(r_di) >= 32'(r_len));

`ifdef SEG_SCANNER_BLINK_EN
  assign w_dark = blink_i && (32'(r_fc) >= 32'(SCROLL_FRAMES / 2));
`else
  assign w_dark = 1'b0;
`endif

  // Digit 0 is leftmost, i.e. the MSB of the enable vector.
  always_comb begin
    w_an = '1;
    for (int k = 0; k < N_DIG; k++) begin
      w_an[k] = ((32'(r_di) + 32'(k)) != (NDIG_U - 32'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      r_msg[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rc    <= '0;
      r_di    <= '0;
      r_fc    <= '0;
      r_off   <= '0;
      r_len   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (bus.stop) begin
        r_state <= S_IDLE;
        r_rc    <= '0;
        r_di    <= '0;
        r_fc    <= '0;
        r_off   <= '0;
      end else if (w_accept) begin
        r_state <= S_RUN;
        r_rc    <= '0;
        r_di    <= '0;
        r_fc    <= '0;
        r_off   <= '0;
        r_len   <= w_len_clamp;
      end else if (w_active) begin
        r_state <= bus.hold ? S_HOLD : S_RUN;
        r_rc    <= w_tick ? '0 : r_rc + RCW'(1);
        if (w_tick) begin
          r_di <= (r_di == DIW'(N_DIG - 1)) ? '0 : r_di + DIW'(1);
        end
        if (w_frame_end && (r_state == S_RUN)) begin
          r_fc <= w_fc_last ? '0 : r_fc + FW'(1);
          if (w_fc_last && w_long) begin
            r_off  <= w_off_nxt;
            r_wrap <= (w_off_nxt == '0);
          end
        end
      end
    end
  end

  // Display registers lag the index by one clock; a (re)start shows one dark cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an    <= '1;
      r_code  <= '0;
      r_blank <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= w_accept || (w_active && !bus.stop);
      if (!w_active || bus.stop || w_accept || w_dark) begin
        r_an    <= '1;
        r_code  <= '0;
        r_blank <= 1'b1;
      end else begin
        r_an    <= w_an;
        r_blank <= w_blank_dig;
        r_code  <= w_blank_dig ? 5'd0 : r_msg[w_rd_addr];
      end
    end
  end

  assign bus.code_o   = r_code;
  assign bus.dig_an_o = r_an;
  assign bus.blank_o  = r_blank;
  assign bus.busy     = r_busy;
  assign bus.wrap_o   = r_wrap;
endmodule

// File: tb/tb_seg_msg_scanner.sv
// tb/tb_seg_msg_scanner.sv - directed scoreboard bench for seg_msg_scanner
module tb_seg_msg_scanner;
  localparam int N_DIG         = 4;
  localparam int MSG_DEPTH     = 8;
  localparam int REFRESH_DIV   = 4;
  localparam int SCROLL_FRAMES = 2;
  localparam logic [11:0] IDLE_VEC = {4'b1111, 5'd0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_msg_scanner_if #(.N_DIG(N_DIG), .MSG_DEPTH(MSG_DEPTH)) bus ();
`ifdef SEG_SCANNER_BLINK_EN
  logic blink_i = 1'b0;
`endif

  seg_msg_scanner #(
    .N_DIG(N_DIG), .MSG_DEPTH(MSG_DEPTH),
    .REFRESH_DIV(REFRESH_DIV), .SCROLL_FRAMES(SCROLL_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef SEG_SCANNER_BLINK_EN
    .blink_i(blink_i),
`endif
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [4:0]  tb_msg [MSG_DEPTH];
  logic [11:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {bus.dig_an_o, bus.code_o, bus.blank_o, bus.wrap_o, bus.busy};
  endfunction

  // Sample k (k>=1 clocks after the start edge) shows the index state from clock k-1.
  function automatic logic [11:0] exp_vec(input int k, input int len);
    int j, di, off;
    logic [3:0] an;
    logic [4:0] code;
    logic bl, wr;
    j   = k - 1;
    di  = (j / 4) % 4;
    off = (len > 4) ? (j / 32) % len : 0;
    an  = ~(4'b1000 >> di);
    if (len <= 4 && di >= len) begin
      code = 5'd0;
      bl   = 1'b1;
    end else begin
      code = tb_msg[(off + di) % len];
      bl   = 1'b0;
    end
    wr = (len > 4) && (k % (32 * len) == 0);
    return {an, code, bl, wr, 1'b1};
  endfunction

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = 5'(d);
    tb_msg[a]   = 5'(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(input int len);
    bus.len_i = 4'(len);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
  endtask

  task automatic run_sb(input int n, input int len, input string tag);
    for (int k = 1; k <= n; k++) sb_q.push_back(exp_vec(k, len));
    while (sb_q.size() > 0) begin
      @(negedge clk);
      chk(tag, 32'(obs_vec()), 32'(sb_q.pop_front()));
    end
  endtask

  initial begin
    int seen0, seen3, found;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len_i = '0;   bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("idle", 32'(obs_vec()), 32'(IDLE_VEC));
    end

    wr(0, 1); wr(1, 2); wr(2, 3);
    do_start(3);
    @(negedge clk);
    chk("busy_rise", 32'(bus.busy), 32'd1);
    run_sb(48, 3, "static");

    for (int a = 0; a < 6; a++) wr(a, a + 1);
    do_start(6);
    @(negedge clk);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    run_sb(400, 6, "scroll");
    do_stop();
    @(negedge clk);
    chk("stop_idle", 32'(obs_vec()), 32'(IDLE_VEC));

    do_start(6);
    @(negedge clk);
    chk("hold_start_busy", 32'(bus.busy), 32'd1);
    run_sb(40, 6, "pre_hold");
    bus.hold = 1'b1;
    seen0 = 0;
    seen3 = 0;
    repeat (100) begin
      @(negedge clk);
      chk("hold_busy", 32'(bus.busy), 32'd1);
      if (bus.dig_an_o == 4'b0111) begin
        seen0++;
        chk("hold_off", 32'(bus.code_o), 32'd2);
      end
      if (bus.dig_an_o == 4'b1110) seen3++;
    end
    chk("hold_scan", {30'd0, seen0 > 0, seen3 > 0}, 32'd3);
    bus.hold = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (bus.dig_an_o == 4'b0111 && bus.code_o == 5'd3) found = 1;
    end
    chk("hold_resume", 32'(found), 32'd1);

    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst", 32'(obs_vec()), 32'(IDLE_VEC));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", 32'(obs_vec()), 32'(IDLE_VEC));

    do_start(0);
    repeat (5) begin
      @(negedge clk);
      chk("len0", 32'(obs_vec()), 32'(IDLE_VEC));
    end

    bus.len_i = 4'd3;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("start_stop", 32'(obs_vec()), 32'(IDLE_VEC));
    end

    for (int a = 0; a < 8; a++) wr(a, a + 10);
    do_start(15);
    @(negedge clk);
    chk("clamp_busy", 32'(bus.busy), 32'd1);
    run_sb(260, 8, "clamp");
    do_stop();
    @(negedge clk);
    chk("final_idle", 32'(obs_vec()), 32'(IDLE_VEC));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
